// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Receives a length-prefixed big-endian byte stream and writes 32-bit words to
// consecutive word addresses starting at 0. The CPU is held in reset until the
// whole program has been written.
module imem_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam int unsigned CAP   = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_FLUSH,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    logic [15:0]        len;
    logic [23:0]        shift_q;
    logic [1:0]         byte_cnt;
    logic [IDX_W-1:0]   word_idx;

    logic               accept_c;
    logic [15:0]        len_full_c;
    logic               last_word_c;

    // Handshake and frame-position decodes.
    assign accept_c    = in_valid && in_ready;
    assign len_full_c  = {len[15:8], in_data};
    assign last_word_c = (32'(word_idx) + 32'd1) == 32'(len);

    // Frame-parsing FSM with registered outputs; writes issue the cycle after the 4th byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_LEN_HI;
            len        <= '0;
            shift_q    <= '0;
            byte_cnt   <= '0;
            word_idx   <= '0;
            in_ready   <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_LEN_HI: begin
                    if (accept_c) begin
                        len[15:8] <= in_data;
                        state     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept_c) begin
                        len[7:0] <= in_data;
                        if (len_full_c == 16'd0) begin
                            state    <= S_DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if (32'(len_full_c) > CAP) begin
                            state    <= S_ERR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept_c) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            imem_wdata <= {shift_q, in_data};
                            imem_addr  <= 32'({word_idx[ADDR_W-1:0], 2'b00});
                            imem_we    <= 1'b1;
                            word_idx   <= word_idx + IDX_W'(1);
                            if (last_word_c) begin
                                state    <= S_FLUSH;
                                in_ready <= 1'b0;
                            end
                        end else begin
                            shift_q <= {shift_q[15:0], in_data};
                        end
                    end
                end
                S_FLUSH: begin
                    state    <= S_DONE;
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
                end
                S_DONE, S_ERR: begin
                    state <= state;
                end
                default: begin
                    state <= S_LEN_HI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte gaps and frames,
// scored against a frame-level model of the expected writes.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    imem_loader #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  frame[$];
    logic [63:0] got[$];
    logic [63:0] exp_w[$];
    bit          exp_done;
    bit          exp_err;
    bit          double_pulse;
    logic        prev_we = 1'b0;
    bit          last_ok;

    // Capture every write strobe mid-cycle and flag strobes longer than one cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            got.push_back({imem_addr, imem_wdata});
            if (prev_we === 1'b1) double_pulse <= 1'b1;
        end
        prev_we <= imem_we;
    end

    // Reference model: derive expected writes and end state from the frame bytes.
    task automatic build_expect();
        int n;
        exp_w.delete();
        n = {frame[0], frame[1]};
        exp_done = (n == 0);
        exp_err  = (n > 256);
        if (!exp_err) begin
            exp_done = 1'b1;
            for (int i = 0; i < n; i++) begin
                exp_w.push_back({32'(i * 4),
                                 frame[2 + 4*i], frame[3 + 4*i],
                                 frame[4 + 4*i], frame[5 + 4*i]});
            end
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got.delete();
        double_pulse = 1'b0;
    endtask

    // Offer one byte after a random gap; returns at #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        while (int'($urandom_range(99)) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        last_ok  = 1'b0;
        for (int k = 0; k < 20 && !last_ok; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) last_ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!last_ok) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout byte=%02h in_ready=%b required accept", b, in_ready);
        end
    endtask

    task automatic send_frame(input int gap_pct);
        foreach (frame[i]) send_byte(frame[i], gap_pct);
    endtask

    task automatic set_two_word();
        frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({cpu_hold, in_ready, done, error, imem_we} !== 5'b11000 ||
            imem_addr !== 32'd0 || imem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset hold/rdy/done/err/we=%b addr=%h wdata=%h required 11000/0/0",
                     {cpu_hold, in_ready, done, error, imem_we}, imem_addr, imem_wdata);
        end
    endtask

    task automatic test_two_word();
        do_reset();
        set_two_word();
        build_expect();
        send_frame(0);
        checks++;
        if (imem_we !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL two_word_flush we=%b done=%b rdy=%b required 1 0 0", imem_we, done, in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL two_word_done done=%b hold=%b err=%b required 1 0 0", done, cpu_hold, error);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got.size() !== exp_w.size() || double_pulse) begin
            errors++;
            $display("FAIL two_word_count writes=%0d dbl=%0d required %0d 0", got.size(), double_pulse, exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL two_word_write%0d got=%h required %h", i, got[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_empty();
        do_reset();
        frame = '{8'h00, 8'h00};
        send_frame(0);
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || in_ready !== 1'b0 || imem_we !== 1'b0) begin
            errors++;
            $display("FAIL empty_done done=%b hold=%b rdy=%b we=%b required 1 0 0 0",
                     done, cpu_hold, in_ready, imem_we);
        end
        in_valid = 1'b1;
        in_data  = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL empty_late_ready rdy=%b required 0", in_ready);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got.size() !== 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL empty_no_write writes=%0d done=%b required 0 1", got.size(), done);
        end
    endtask

    task automatic test_oversize();
        do_reset();
        frame = '{8'h01, 8'h01};
        send_frame(0);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (error !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0 || got.size() !== 0) begin
            errors++;
            $display("FAIL oversize err=%b hold=%b rdy=%b done=%b writes=%0d required 1 1 0 0 0",
                     error, cpu_hold, in_ready, done, got.size());
        end
    endtask

    task automatic test_max();
        do_reset();
        frame = '{8'h01, 8'h00};
        for (int i = 0; i < 1024; i++) frame.push_back(8'($urandom));
        build_expect();
        send_frame(0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got.size() !== 256 || done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL max_count writes=%0d done=%b err=%b required 256 1 0", got.size(), done, error);
        end
        checks++;
        if (got.size() == 0 || got[got.size()-1][63:32] !== 32'h0000_03FC) begin
            errors++;
            $display("FAIL max_last_addr got=%h required 000003fc",
                     (got.size() == 0) ? 32'hx : got[got.size()-1][63:32]);
        end
        for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL max_write%0d got=%h required %h", i, got[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_gaps();
        do_reset();
        set_two_word();
        build_expect();
        send_frame(50);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got.size() !== exp_w.size() || double_pulse || done !== 1'b1) begin
            errors++;
            $display("FAIL gaps_count writes=%0d dbl=%0d done=%b required %0d 0 1",
                     got.size(), double_pulse, done, exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL gaps_write%0d got=%h required %h", i, got[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        set_two_word();
        for (int i = 0; i < 6; i++) send_byte(frame[i], 0);
        // Reset lands on the edge where another byte is also offered.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (got.size() !== 1 || imem_we !== 1'b0 || in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL rst_abort writes=%0d we=%b rdy=%b hold=%b required 1 0 1 1",
                     got.size(), imem_we, in_ready, cpu_hold);
        end
        // Partial word (2 data bytes) must be discarded by a second reset.
        got.delete();
        frame = '{8'h00, 8'h02, 8'hAA, 8'hBB};
        send_frame(0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_two_word();
        build_expect();
        send_frame(25);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got.size() !== exp_w.size() || done !== 1'b1) begin
            errors++;
            $display("FAIL rst_reload_count writes=%0d done=%b required %0d 1", got.size(), done, exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL rst_reload_write%0d got=%h required %h", i, got[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int n;
            do_reset();
            n = int'($urandom_range(6, 1));
            frame = '{8'h00, 8'(n)};
            for (int i = 0; i < 4*n; i++) frame.push_back(8'($urandom));
            build_expect();
            send_frame(int'($urandom_range(60)));
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (got.size() !== exp_w.size() || double_pulse || done !== exp_done || error !== exp_err) begin
                errors++;
                $display("FAIL random%0d writes=%0d dbl=%0d done=%b err=%b required %0d 0 %b %b",
                         r, got.size(), double_pulse, done, error, exp_w.size(), exp_done, exp_err);
            end
            for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
                checks++;
                if (got[i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL random%0d_write%0d got=%h required %h", r, i, got[i], exp_w[i]);
                end
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_two_word();
        test_empty();
        test_oversize();
        test_max();
        test_gaps();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
